// File: rtl/fifo_read_ctrl_pkg.sv
// Shared FIFO constants for the writer and reader sides.
// Pointers carry one extra wrap bit above the storage address.
package fifo_read_ctrl_pkg;

  localparam int FIFO_DEPTH_DEF = 8;
  localparam int DATA_WIDTH_DEF = 8;

  function automatic int ptr_aw(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_read_ctrl.sv
// Read side of a synchronous FIFO: one-entry registered output stage fed from
// storage, with flush, occupancy count and a sticky overflow flag.
module fifo_read_ctrl
  import fifo_read_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  localparam int AW        = ptr_aw(FIFO_DEPTH)
) (
  input  logic                  r_clk,
  input  logic                  rst,
  input  logic [AW:0]           w_ptr,
  input  logic [DATA_WIDTH-1:0] r_data,
  input  logic                  out_ready,
  input  logic                  flush,
  output logic [AW-1:0]         r_addr,
  output logic [AW:0]           r_ptr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  empty,
  output logic [AW:0]           count,
  output logic                  ovf_err
);

  localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(FIFO_DEPTH);

  logic [AW:0]           r_ptr_q, r_ptr_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  ovf_q, ovf_d;
  logic                  xfer, load;

  assign empty = (r_ptr_q == w_ptr);
  assign count = w_ptr - r_ptr_q;
  assign xfer  = out_valid_q & out_ready;
  assign load  = ~flush & ~empty & (~out_valid_q | xfer);

  always_comb begin
    r_ptr_d     = r_ptr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    // Flush wins; a transfer in the same cycle has already been delivered.
    if (flush) begin
      r_ptr_d     = w_ptr;
      out_valid_d = 1'b0;
    end else if (load) begin
      r_ptr_d     = r_ptr_q + PTR_ONE;
      out_data_d  = r_data;
      out_valid_d = 1'b1;
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
    ovf_d = ovf_q | ({1'b0, count} > DEPTH_W);
  end

  always_ff @(posedge r_clk or posedge rst) begin
    if (rst) begin
      r_ptr_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      r_ptr_q     <= r_ptr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign r_ptr     = r_ptr_q;
  assign r_addr    = r_ptr_q[AW-1:0];
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl (DEPTH 8): the bench plays the writer and
// owns the storage array, so every expected value comes from its own pointer.
module tb_fifo_read_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] w_ptr;
  logic [7:0] r_data;
  logic       out_ready;
  logic       flush;
  logic [2:0] r_addr;
  logic [3:0] r_ptr;
  logic [7:0] out_data;
  logic       out_valid;
  logic       empty;
  logic [3:0] count;
  logic       ovf_err;

  logic [7:0] mem [8];
  int checks = 0;
  int errors = 0;

  fifo_read_ctrl #(.FIFO_DEPTH(8), .DATA_WIDTH(8)) dut (
    .r_clk(clk), .rst(rst), .w_ptr(w_ptr), .r_data(r_data),
    .out_ready(out_ready), .flush(flush), .r_addr(r_addr), .r_ptr(r_ptr),
    .out_data(out_data), .out_valid(out_valid), .empty(empty),
    .count(count), .ovf_err(ovf_err)
  );

  assign r_data = mem[r_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    mem[w_ptr[2:0]] = d;
    w_ptr = w_ptr + 4'd1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; w_ptr = 4'd0;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    #2;
    checks++; if (r_ptr !== 4'd0) begin errors++; $display("FAIL reset_r_ptr got %0h want 0", r_ptr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %0h want 0", out_data); end
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf_err); end
    checks++; if (empty !== 1'b1 || count !== 4'd0) begin errors++; $display("FAIL reset_empty_count got %b/%0d want 1/0", empty, count); end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'hA1; exp_d[1] = 8'hA2; exp_d[2] = 8'hA3;
    out_ready = 1'b1;
    push(8'hA1);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_latency got valid %b want 0", out_valid); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_d[i]) begin
        errors++; $display("FAIL basic_data%0d got %b/%0h want 1/%0h", i, out_valid, out_data, exp_d[i]);
      end
      if (i < 2) push(exp_d[i+1]);
    end
    step();
    checks++; if (out_valid !== 1'b0 || out_data !== 8'hA3) begin errors++; $display("FAIL basic_drain got %b/%0h want 0/a3", out_valid, out_data); end
    checks++; if (empty !== 1'b1 || count !== 4'd0) begin errors++; $display("FAIL basic_empty got %b/%0d want 1/0", empty, count); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h10 || count !== 4'd7) begin
        errors++; $display("FAIL bp_hold%0d got %b/%0h/%0d want 1/10/7", k, out_valid, out_data, count);
      end
    end
    out_ready = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h10 + 8'(k)) begin
        errors++; $display("FAIL bp_stream%0d got %b/%0h want 1/%0h", k, out_valid, out_data, 8'h10 + 8'(k));
      end
    end
    step();
    checks++; if (out_valid !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL bp_end got valid %b empty %b want 0/1", out_valid, empty); end
  endtask

  task automatic test_wrap();
    logic [7:0] q [$];
    logic [7:0] exp;
    logic [3:0] prev_r;
    int pushed = 0;
    int got = 0;
    int cyc = 0;
    bit wrapped = 0;
    bit order_ok = 1;
    prev_r = r_ptr;
    while (got < 40 && cyc < 1000) begin
      out_ready = 1'($urandom_range(0, 1));
      if (pushed < 40 && 4'(w_ptr - r_ptr) < 4'd8) begin
        push(8'h40 + 8'(pushed));
        q.push_back(8'h40 + 8'(pushed));
        pushed++;
      end
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          order_ok = 0;
          errors++; checks++; $display("FAIL wrap_dup got %0h want no entry", out_data);
        end else begin
          exp = q.pop_front();
          if (out_data !== exp) begin
            order_ok = 0;
            $display("FAIL wrap_order got %0h want %0h", out_data, exp);
          end
        end
        got++;
      end
      step();
      if (prev_r == 4'd15 && r_ptr == 4'd0) wrapped = 1;
      prev_r = r_ptr;
      cyc++;
    end
    out_ready = 1'b0;
    checks++; if (got !== 40) begin errors++; $display("FAIL wrap_count got %0d want 40", got); end
    checks++; if (!order_ok) begin errors++; $display("FAIL wrap_inorder got misordered want in-order"); end
    checks++; if (!wrapped) begin errors++; $display("FAIL wrap_ptr got no 15->0 want wrap"); end
    checks++; if (ovf_err !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL wrap_final got ovf %b empty %b want 0/1", ovf_err, empty); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'h80 + 8'(i));
    step();
    checks++; if (out_valid !== 1'b1 || count !== 4'd4) begin errors++; $display("FAIL flush_pre got %b/%0d want 1/4", out_valid, count); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", out_valid); end
    checks++; if (r_ptr !== w_ptr || empty !== 1'b1) begin errors++; $display("FAIL flush_ptr got %0h/%b want %0h/1", r_ptr, empty, w_ptr); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_after got %b want 0", out_valid); end
  endtask

  task automatic test_ovf();
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_pre got %b want 0", ovf_err); end
    w_ptr = w_ptr + 4'd9;
    #1;
    checks++; if (count !== 4'd9) begin errors++; $display("FAIL ovf_count got %0d want 9", count); end
    step();
    checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", ovf_err); end
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) step();
    checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", ovf_err); end
    rst = 1'b1; w_ptr = 4'd0;
    #1;
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", ovf_err); end
    step();
    rst = 1'b0;
    out_ready = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    push(8'h5A); push(8'h5B);
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h5A) begin errors++; $display("FAIL ar_pre got %b/%0h want 1/5a", out_valid, out_data); end
    #3;
    rst = 1'b1; w_ptr = 4'd0;
    #1;
    checks++; if (out_valid !== 1'b0 || r_ptr !== 4'd0 || out_data !== 8'h00) begin
      errors++; $display("FAIL ar_immediate got %b/%0h/%0h want 0/0/0", out_valid, r_ptr, out_data);
    end
    step();
    rst = 1'b0;
    push(8'h55);
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h55 || r_ptr !== 4'd1) begin
      errors++; $display("FAIL ar_resume got %b/%0h/%0h want 1/55/1", out_valid, out_data, r_ptr);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_flush();
    test_ovf();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
